// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {instr, pc2} with flush and NOP-on-empty.
// Optional IFID_BUBBLE_CNT_EN adds a saturating decode-starvation counter on bubble_cnt.
module if_id_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_valid,
  input  logic [15:0]              f_instr,
  input  logic [15:0]              f_pc2,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [15:0]              d_instr,
  output logic [15:0]              d_pc2,
  input  logic                     d_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [15:0]              bubble_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   head;
  logic          push, pop;

  // Ready depends only on registered occupancy, never on d_ready.
  assign f_ready = (count_q != CW'(DEPTH));
  assign d_valid = (count_q != '0);
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;

  assign head    = mem_q[rd_ptr_q];
  assign d_instr = d_valid ? head[31:16] : NOP_INSTR;
  assign d_pc2   = d_valid ? head[15:0]  : 16'h0000;
  assign count   = count_q;
  assign err     = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Overflow: fetch kept f_valid high against a full queue.
    err_d    = err_q | (f_valid & ~f_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {f_instr, f_pc2};
  end

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (d_ready && !d_valid && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_q <= '0;
    else      bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = CW + 35;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              f_valid = 1'b0, d_ready = 1'b0, flush = 1'b0;
  logic [15:0]       f_instr = '0, f_pc2 = '0;
  logic              f_ready, d_valid, err;
  logic [15:0]       d_instr, d_pc2;
  logic [CW-1:0]     count;
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0]       bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          merr;
  int          mbub;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc2(f_pc2), .f_ready(f_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc2(d_pc2), .d_ready(d_ready),
    .flush(flush), .count(count), .err(err)
`ifdef IFID_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [VW-1:0] act;
  assign act = {count, d_valid, f_ready, d_instr, d_pc2, err};

  function automatic logic [VW-1:0] exp_vec();
    logic        vld;
    logic [15:0] ins, pc;
    vld = (mq.size() != 0);
    ins = vld ? mq[0][31:16] : 16'h0800;
    pc  = vld ? mq[0][15:0]  : 16'h0000;
    return {CW'(mq.size()), vld, (mq.size() != DEPTH), ins, pc, merr};
  endfunction

  task automatic model_clear();
    mq.delete();
    merr = 1'b0;
    mbub = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit full, empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (f_valid && full && !flush) merr = 1'b1;
    if (d_ready && empty && mbub < 65535) mbub++;
    if (flush) mq.delete();
    else begin
      if (d_ready && !empty) void'(mq.pop_front());
      if (f_valid && !full) mq.push_back({f_instr, f_pc2});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0; f_instr = '0; f_pc2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    model_clear();
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", act, exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_fill_overflow();
    d_ready = 1'b0; f_valid = 1'b1; f_instr = 16'hC005; f_pc2 = 16'h0002;
    tick();
    f_instr = 16'hD1A0; f_pc2 = 16'h0004;
    tick();
    checks++;
    if (act !== exp_vec() || count !== 2 || f_ready !== 1'b0 || d_instr !== 16'hC005 || d_pc2 !== 16'h0002) begin
      errors++; $display("FAIL fill_full: got %h expected %h", act, exp_vec());
    end
    tick();
    checks++;
    if (err !== 1'b1 || act !== exp_vec()) begin
      errors++; $display("FAIL overflow_err: got err=%b vec %h expected err=1 vec %h", err, act, exp_vec());
    end
    f_valid = 1'b0;
    tick(); tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b expected 1", err);
    end
    test_reset();
  endtask

  task automatic test_order_wrap();
    logic [15:0] seen[$];
    int pushed = 0;
    d_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (d_valid) seen.push_back(d_instr);
      f_valid = (pushed < 5) && f_ready;
      f_instr = 16'h1001 + 16'(pushed);
      f_pc2   = 16'(2 * pushed + 2);
      if (f_valid) pushed++;
      tick();
      checks++;
      if (act !== exp_vec() || count > 2) begin
        errors++; $display("FAIL order_cycle%0d: got %h expected %h", cyc, act, exp_vec());
      end
    end
    checks++;
    if (seen.size() != 5) begin
      errors++; $display("FAIL order_len: got %0d expected 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] !== 16'h1001 + 16'(i)) begin
          errors++; $display("FAIL order_item%0d: got %h expected %h", i, seen[i], 16'h1001 + 16'(i));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_simul_push_pop();
    f_valid = 1'b1; f_instr = 16'hA001; f_pc2 = 16'h0100; d_ready = 1'b0;
    tick();
    f_instr = 16'hA002; f_pc2 = 16'h0102; d_ready = 1'b1;
    tick();
    checks++;
    if (count !== 1 || d_instr !== 16'hA002 || d_pc2 !== 16'h0102 || act !== exp_vec()) begin
      errors++; $display("FAIL simul_push_pop: got %h expected %h", act, exp_vec());
    end
    f_valid = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    f_valid = 1'b1; d_ready = 1'b0;
    f_instr = 16'hB001; f_pc2 = 16'h0200; tick();
    f_instr = 16'hB002; f_pc2 = 16'h0202; tick();
    f_instr = 16'hBAD0; f_pc2 = 16'h0204; flush = 1'b1;
    tick();
    checks++;
    if (count !== 0 || d_valid !== 1'b0 || d_instr !== 16'h0800 || act !== exp_vec()) begin
      errors++; $display("FAIL flush_clear: got %h expected %h", act, exp_vec());
    end
    idle_inputs();
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (d_instr === 16'hBAD0 || act !== exp_vec()) begin
        errors++; $display("FAIL flush_drop%0d: got %h expected %h", i, act, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      f_valid = ($urandom_range(0, 2) != 0) && (mq.size() < DEPTH || $urandom_range(0, 31) == 0);
      f_instr = 16'($urandom);
      f_pc2   = 16'($urandom);
      d_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", cyc, act, exp_vec());
      end
`ifdef IFID_BUBBLE_CNT_EN
      checks++;
      if (bubble_cnt !== 16'(mbub)) begin
        errors++; $display("FAIL bubble_cycle%0d: got %0d expected %0d", cyc, bubble_cnt, mbub);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    f_valid = 1'b1; d_ready = 1'b0;
    f_instr = 16'hE001; f_pc2 = 16'h0300; tick();
    f_instr = 16'hE002; f_pc2 = 16'h0302; tick();
    f_valid = 1'b0;
    checks++;
    if (count !== 2) begin
      errors++; $display("FAIL async_pre: got count %0d expected 2", count);
    end
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if (count !== 0 || d_instr !== 16'h0800 || act !== exp_vec()) begin
      errors++; $display("FAIL async_reset: got %h expected %h", act, exp_vec());
    end
`ifdef IFID_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'h0000) begin
      errors++; $display("FAIL async_bubble: got %0d expected 0", bubble_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL async_after: got %h expected %h", act, exp_vec());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill_overflow();
    test_order_wrap();
    test_simul_push_pop();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
